vproc_mem_model: RTL
====================

VPROC_MEM_MODEL -- requirements
Module: vproc_mem_model

Interface
REQ-001 SHALL have parameter MEM_W, default 32, data word width in bits (multiple of 32).
REQ-002 SHALL have parameter MEM_SZ, default 262144, memory size in bytes (power of two).
REQ-003 SHALL have parameter LATENCY, default 1, grant-to-response cycles (>=1).
REQ-004 SHALL have parameter NPORTS, default 2, requester channel count (1..4).
REQ-005 SHALL have parameter ADDR_BASE, default 32'h0, first valid byte address.
REQ-006 SHALL have parameter END_ADDR, default 32'h0, address whose granted request signals program end.
REQ-007 SHALL have port clk_i  input  1  sole clock; all state on its rising edge.
REQ-008 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port req_i  input  NPORTS  per-port request.
REQ-010 SHALL have port addr_i  input  NPORTSx32  per-port byte address.
REQ-011 SHALL have port we_i  input  NPORTS  per-port write enable.
REQ-012 SHALL have port be_i  input  NPORTSx(MEM_W/8)  per-port byte enables.
REQ-013 SHALL have port wdata_i  input  NPORTSxMEM_W  per-port write data.
REQ-014 SHALL have port gnt_o  output  NPORTS  per-port grant (combinational, same cycle as req).
REQ-015 SHALL have port rvalid_o  output  NPORTS  per-port response valid.
REQ-016 SHALL have port err_o  output  NPORTS  per-port response error, qualified by rvalid_o.
REQ-017 SHALL have port rdata_o  output  NPORTSxMEM_W  per-port read data, qualified by rvalid_o.
REQ-018 SHALL have port done_o  output  1  sticky program-end flag.

Function
REQ-019 SHALL grant at most one request per cycle, round-robin, priority pointer advancing to the port after the last granted one; a single requester SHALL be granted every cycle.
REQ-020 SHALL hold an ungranted request pending; the requester keeps req/addr/we/be/wdata stable until gnt_o.
REQ-021 SHALL index memory by addr[$clog2(MEM_SZ)-1:$clog2(MEM_W/8)] of (addr-ADDR_BASE); sub-word address bits ignored.
REQ-022 SHALL flag error when addr < ADDR_BASE or addr >= ADDR_BASE+MEM_SZ (32-bit compare, no wrap).
REQ-023 SHALL on a granted in-range write update only bytes with be_i set, at the grant edge; an erroneous write SHALL not modify memory.
REQ-024 SHALL return exactly one response per grant, on the granted port, LATENCY cycles after the grant cycle, in grant order; writes respond with rdata_o=0.
REQ-025 SHALL return read data sampled at the grant edge; a read granted the cycle after a write to the same word returns the written bytes.
REQ-026 SHALL drive rdata_o=0 and err_o=1 for erroneous requests.
REQ-027 SHALL keep rvalid_o/err_o/rdata_o zero on ports with no response due.
REQ-028 SHALL set done_o the cycle after granting any request with addr==END_ADDR and hold it until reset.
REQ-029 SHALL sustain one grant per cycle with LATENCY-deep pipeline fully occupied (no bubbles).

Reset
REQ-030 SHALL clear rvalid_o, err_o, rdata_o, done_o, pipeline stages and round-robin pointer (port 0 highest) asynchronously when rst_ni low.
REQ-031 SHALL discard in-flight responses on reset mid-operation; no response for pre-reset grants appears after reset release.
REQ-032 SHALL not reset memory contents; gnt_o SHALL be 0 while rst_ni low.

Structure
REQ-033 SHALL place the response-stage struct (valid, err, port index, rdata) and port-index width constant in shared package vproc_mem_pkg.
REQ-034 SHALL implement arbitration in one sub-module vproc_mem_rr_arb (NPORTS req in, one-hot gnt out, pointer state).
REQ-035 SHALL keep the memory array as a non-reset register array loadable by $readmemh from the bench.

Verification
REQ-036 SHALL cover: LATENCY=3, port0 read addr 0x10 with mem word 0xDEADBEEF -> gnt same cycle, rvalid_o[0]=1 with 0xDEADBEEF exactly 3 cycles later.
REQ-037 SHALL cover: ports 0 and 1 requesting continuously 4 cycles -> grants alternate 0,1,0,1, responses in same order.
REQ-038 SHALL cover: write 0x11223344 be=4'b0101 to word holding 0xAAAAAAAA, then read -> 0xAA22AA44.
REQ-039 SHALL cover: read addr ADDR_BASE+MEM_SZ -> err_o=1, rdata_o=0; write there leaves memory unchanged.
REQ-040 SHALL cover: reset asserted with 2 responses in flight -> outputs 0 immediately, no rvalid after release; request to END_ADDR -> done_o=1 next cycle, held.

Source files
------------

// File: rtl/vproc_mem_pkg.sv
// Shared types for the vproc memory model: response pipeline stage layout
// and the width of a requester port index.
package vproc_mem_pkg;

   localparam int PORT_W      = 2;    // up to four requesters
   localparam int RDATA_MAX_W = 512;  // widest supported MEM_W; narrower users leave upper bits zero

   typedef struct packed {
      logic                   valid;
      logic                   err;
      logic [PORT_W-1:0]      port;
      logic [RDATA_MAX_W-1:0] rdata;
   } rsp_stage_t;

endpackage

// File: rtl/vproc_mem_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority pointer moves to the port
// after the most recently granted one.
module vproc_mem_rr_arb
   import vproc_mem_pkg::*;
#(
   parameter int NPORTS = 2
)(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NPORTS-1:0] req,
   output logic [NPORTS-1:0] gnt
);

   logic [PORT_W-1:0] ptr_reg;
   logic [PORT_W-1:0] ptr_next;
   logic              found;

   // First pass covers ports at or above the pointer, second pass wraps around.
   always_comb begin
      gnt      = '0;
      ptr_next = ptr_reg;
      found    = 1'b0;
      for (int j = 0; j < NPORTS; j++) begin
         if (!found && req[j] && (PORT_W'(j) >= ptr_reg)) begin
            gnt[j]   = 1'b1;
            found    = 1'b1;
            ptr_next = PORT_W'((j + 1) % NPORTS);
         end
      end
      for (int j = 0; j < NPORTS; j++) begin
         if (!found && req[j]) begin
            gnt[j]   = 1'b1;
            found    = 1'b1;
            ptr_next = PORT_W'((j + 1) % NPORTS);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/vproc_mem_model.sv
// Multi-port memory model for the vector processor: round-robin access to a
// single word array, fixed-latency in-order responses and a program-end flag.
module vproc_mem_model
   import vproc_mem_pkg::*;
#(
   parameter int          MEM_W     = 32,
   parameter int          MEM_SZ    = 262144,
   parameter int          LATENCY   = 1,
   parameter int          NPORTS    = 2,
   parameter logic [31:0] ADDR_BASE = 32'h0,
   parameter logic [31:0] END_ADDR  = 32'h0
)(
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NPORTS-1:0]           req_i,
   input  logic [NPORTS*32-1:0]        addr_i,
   input  logic [NPORTS-1:0]           we_i,
   input  logic [NPORTS*(MEM_W/8)-1:0] be_i,
   input  logic [NPORTS*MEM_W-1:0]     wdata_i,
   output logic [NPORTS-1:0]           gnt_o,
   output logic [NPORTS-1:0]           rvalid_o,
   output logic [NPORTS-1:0]           err_o,
   output logic [NPORTS*MEM_W-1:0]     rdata_o,
   output logic                        done_o
);

   localparam int BE_W  = MEM_W / 8;
   localparam int AW    = $clog2(MEM_SZ);
   localparam int WB    = $clog2(BE_W);
   localparam int DEPTH = MEM_SZ / BE_W;

   logic [NPORTS-1:0] arb_gnt;
   logic              any_gnt;
   logic [PORT_W-1:0] g_port;
   logic [31:0]       g_addr;
   logic              g_we;
   logic [BE_W-1:0]   g_be;
   logic [MEM_W-1:0]  g_wdata;
   logic [32:0]       g_off;
   logic              g_err;
   logic [AW-WB-1:0]  g_idx;

   logic [MEM_W-1:0]  mem [DEPTH];
   rsp_stage_t        stage_reg [LATENCY];
   rsp_stage_t        stage_next;
   rsp_stage_t        rsp_out;
   logic              done_reg;

   vproc_mem_rr_arb #(.NPORTS(NPORTS)) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (req_i),
      .gnt    (arb_gnt)
   );

   assign gnt_o   = arb_gnt & {NPORTS{rst_ni}};
   assign any_gnt = |gnt_o;

   always_comb begin
      g_port  = '0;
      g_addr  = '0;
      g_we    = 1'b0;
      g_be    = '0;
      g_wdata = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (gnt_o[p]) begin
            g_port  = PORT_W'(p);
            g_addr  = addr_i[p*32 +: 32];
            g_we    = we_i[p];
            g_be    = be_i[p*BE_W +: BE_W];
            g_wdata = wdata_i[p*MEM_W +: MEM_W];
         end
      end
   end

   // 33-bit offset: a borrow means below base, any bit at or above AW means past the end.
   assign g_off = {1'b0, g_addr} - {1'b0, ADDR_BASE};
   assign g_err = g_off[32] | (|g_off[31:AW]);
   assign g_idx = g_off[AW-1:WB];

   always_ff @(posedge clk_i) begin
      if (any_gnt && g_we && !g_err) begin
         for (int b = 0; b < BE_W; b++) begin
            if (g_be[b]) mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
         end
      end
   end

   always_comb begin
      stage_next = '0;
      if (any_gnt) begin
         stage_next.valid = 1'b1;
         stage_next.err   = g_err;
         stage_next.port  = g_port;
         if (!g_we && !g_err) stage_next.rdata = RDATA_MAX_W'(mem[g_idx]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < LATENCY; s++) stage_reg[s] <= '0;
         done_reg <= 1'b0;
      end else begin
         stage_reg[0] <= stage_next;
         for (int s = 1; s < LATENCY; s++) stage_reg[s] <= stage_reg[s-1];
         if (any_gnt && (g_addr == END_ADDR)) done_reg <= 1'b1;
      end
   end

   assign rsp_out = stage_reg[LATENCY-1];
   assign done_o  = done_reg;

   for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rsp
      logic hit;
      assign hit                         = rsp_out.valid && (rsp_out.port == PORT_W'(gi));
      assign rvalid_o[gi]                = hit;
      assign err_o[gi]                   = hit && rsp_out.err;
      assign rdata_o[gi*MEM_W +: MEM_W]  = hit ? rsp_out.rdata[MEM_W-1:0] : '0;
   end

   logic unused_off;
   assign unused_off = ^g_off[WB-1:0];

   if (RDATA_MAX_W > MEM_W) begin : g_unused_rdata
      logic unused_rdata;
      assign unused_rdata = ^rsp_out.rdata[RDATA_MAX_W-1:MEM_W];
   end

endmodule
